// File: rtl/multicycle_controller.sv
// Multicycle sequencer: steps one instruction through FETCH..writeback and drives datapath enables/selects.
// Define MEM_WAIT_EN to hold memory-access states on mem_ready with a MAX_WAIT-cycle timeout.
module multicycle_controller #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic       cond_ex,
    input  logic       mem_ready,
    output logic       ir_w,
    output logic       pc_w,
    output logic       reg_w,
    output logic       mem_w,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       shift_flag,
    output logic       instr_done,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cmd;
    logic       waiting;
    logic       timeout;

    assign cmd = funct[4:1];

    function automatic logic [1:0] alu_op(input logic [3:0] c);
        case (c)
            4'b0100:          return 2'b00;
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

`ifdef MEM_WAIT_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] wait_q, wait_d;
    logic          mem_state;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout   = mem_state && !mem_ready && (wait_q == CW'(MAX_WAIT));
    assign waiting   = mem_state && !mem_ready && !timeout;
    // Any cycle that is not a hold enters a new state (possibly FETCH again), so the count restarts.
    assign wait_d    = waiting ? wait_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (reset) wait_q <= '0;
        else       wait_q <= wait_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = mem_ready & (MAX_WAIT > 0);
    assign waiting    = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state   = reset ? 4'd0 : state_q;
    assign mem_err = timeout & ~reset;

    always_comb begin
        state_d     = S_FETCH;
        ir_w        = 1'b0;
        pc_w        = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        alu_control = 2'b00;
        flag_w      = 2'b00;
        shift_flag  = 1'b0;
        instr_done  = 1'b0;
        if (!reset) begin
            if (state_q <= S_BRANCH)
                imm_src = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
            case (state_q)
                S_FETCH: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    if (!waiting && !timeout) begin
                        ir_w    = 1'b1;
                        pc_w    = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    case (op)
                        2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: instr_done = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_b = 2'b01;
                    state_d   = funct[0] ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    adr_src = 1'b1;
                    if (waiting)       state_d = S_MEMRD;
                    else if (!timeout) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_w      = cond_ex;
                    pc_w       = cond_ex && (rd == 4'd15);
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    adr_src = 1'b1;
                    mem_w   = cond_ex && !timeout;
                    if (waiting)       state_d = S_MEMWR;
                    else if (!timeout) instr_done = 1'b1;
                end
                S_EXECR, S_EXECI: begin
                    alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                    alu_control = alu_op(cmd);
                    flag_w[1]   = funct[0] && cond_ex;
                    flag_w[0]   = funct[0] && cond_ex && !alu_control[1];
                    shift_flag  = (cmd == 4'b1101);
                    state_d     = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_w      = cond_ex && (funct[4:0] != 5'b10101);
                    pc_w       = reg_w && (rd == 4'd15);
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_b  = 2'b01;
                    result_src = 2'b10;
                    pc_w       = cond_ex;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instructions, reset cases, then random instructions
// checked cycle by cycle against a state-path model of each instruction class.
module tb_multicycle_controller;
    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex;
    logic       mem_ready;
    logic       ir_w, pc_w, reg_w, mem_w, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, alu_control, flag_w;
    logic       shift_flag, instr_done, mem_err;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int instr_no = 0;
    int force_low = 0;

    multicycle_controller #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond_ex(cond_ex),
        .mem_ready(mem_ready), .ir_w(ir_w), .pc_w(pc_w), .reg_w(reg_w), .mem_w(mem_w),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
        .flag_w(flag_w), .shift_flag(shift_flag), .instr_done(instr_done),
        .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] dut_vec();
        return {ir_w, pc_w, reg_w, mem_w, adr_src, alu_src_a, alu_src_b, result_src,
                imm_src, alu_control, flag_w, shift_flag, instr_done, mem_err, state};
    endfunction

    function automatic logic [1:0] exp_alu(input logic [3:0] c);
        if (c == 4'b0000) return 2'b10;
        if (c == 4'b1100) return 2'b11;
        if (c == 4'b0010 || c == 4'b1010) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs for one cycle spent in state s of the current instruction.
    function automatic logic [22:0] exp_vec(input int s, input logic [1:0] o, input logic [5:0] f,
                                            input logic [3:0] r, input logic c, input logic last,
                                            input logic stall, input logic tmo);
        logic       ex, wb, irw, pcw, memw, adr, srca, sh, done;
        logic [1:0] srcb, res, imm, alu, fw;
        ex   = (s == 6 || s == 7);
        wb   = (s == 4 && c) || (s == 8 && c && f[4:0] != 5'b10101);
        irw  = (s == 0) && !stall;
        pcw  = irw || (s == 9 && c) || (wb && r == 4'd15);
        memw = (s == 5) && c && !tmo;
        adr  = (s == 3 || s == 5);
        srca = (s == 0 || s == 1);
        srcb = srca ? 2'b10 : (s == 2 || s == 7 || s == 9) ? 2'b01 : 2'b00;
        res  = (srca || s == 9) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
        imm  = (o == 2'b01) ? 2'b01 : (o == 2'b10) ? 2'b10 : 2'b00;
        alu  = ex ? exp_alu(f[4:1]) : 2'b00;
        fw   = ex ? {f[0] & c, f[0] & c & (alu == 2'b00 || alu == 2'b01)} : 2'b00;
        sh   = ex && (f[4:1] == 4'b1101);
        done = last && !stall;
        return {irw, pcw, wb, memw, adr, srca, srcb, res, imm, alu, fw, sh, done, tmo, 4'(s)};
    endfunction

    task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic pick_ready(output logic rdy);
        if (force_low > 0) begin
            force_low--;
            rdy = 1'b0;
        end else begin
            rdy = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Run up to nsteps states of one instruction; the state path depends only on its class.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                             input logic c, input int nsteps);
        int   path[$];
        logic rdy, stall, tmo, last;
        bit   aborted;
        if (o == 2'b11)      path = '{0, 1};
        else if (o == 2'b10) path = '{0, 1, 9};
        else if (o == 2'b01) path = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
        else                 path = f[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
        aborted = 1'b0;
        for (int i = 0; i < path.size() && i < nsteps && !aborted; i++) begin
            for (int w = 0; w <= MAX_WAIT; w++) begin
                @(negedge clk);
                if (i == 0 && w == 0) begin
                    op = o; funct = f; rd = r; cond_ex = c;
                end
                pick_ready(rdy);
                mem_ready = rdy;
                #1;
                stall = 1'b0;
                tmo   = 1'b0;
`ifdef MEM_WAIT_EN
                stall = (path[i] == 0 || path[i] == 3 || path[i] == 5) && !rdy;
                tmo   = stall && (w == MAX_WAIT);
`endif
                last = (i == path.size() - 1);
                check($sformatf("instr%0d_step%0d_wait%0d", instr_no, i, w), dut_vec(),
                      exp_vec(path[i], o, f, r, c, last, stall, tmo));
                if (tmo) aborted = 1'b1;
                if (!stall) break;
            end
        end
        instr_no++;
    endtask

    initial begin
        reset = 1'b1; op = 2'b01; funct = 6'b111111; rd = 4'd15; cond_ex = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check($sformatf("reset_hold%0d", k), dut_vec(), 23'd0);
        end
        @(posedge clk); #1 reset = 1'b0;

        run_instr(2'b00, 6'b001000, 4'd1,  1'b1, 99);  // ADD r1
        run_instr(2'b01, 6'b011001, 4'd2,  1'b1, 99);  // LDR
        run_instr(2'b10, 6'b000000, 4'd0,  1'b0, 99);  // B, condition failed
        run_instr(2'b00, 6'b110101, 4'd0,  1'b1, 99);  // CMPS immediate
        run_instr(2'b00, 6'b010101, 4'd3,  1'b1, 99);  // CMPS register
        run_instr(2'b00, 6'b000101, 4'd15, 1'b1, 99);  // SUBS to PC
        run_instr(2'b01, 6'b000000, 4'd4,  1'b1, 99);  // STR
        run_instr(2'b01, 6'b000000, 4'd4,  1'b0, 99);  // STR, condition failed
        run_instr(2'b01, 6'b100001, 4'd15, 1'b1, 99);  // LDR to PC
        run_instr(2'b00, 6'b111011, 4'd5,  1'b1, 99);  // LSL with S
        run_instr(2'b00, 6'b011001, 4'd6,  1'b1, 99);  // ORRS
        run_instr(2'b00, 6'b000001, 4'd7,  1'b1, 99);  // ANDS
        run_instr(2'b10, 6'b000000, 4'd0,  1'b1, 99);  // B taken
        run_instr(2'b11, 6'b000000, 4'd0,  1'b1, 99);  // illegal

        // Reset in the middle of an LDR, while in MEMRD
        run_instr(2'b01, 6'b000001, 4'd8, 1'b1, 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_in_memrd", dut_vec(), 23'd0);
        @(posedge clk); #1 reset = 1'b0;
        run_instr(2'b11, 6'b101010, 4'd9, 1'b1, 99);

`ifdef MEM_WAIT_EN
        force_low = 3;
        run_instr(2'b00, 6'b001000, 4'd1, 1'b1, 99);
        force_low = MAX_WAIT + 1;
        run_instr(2'b00, 6'b001000, 4'd1, 1'b1, 99);
        run_instr(2'b01, 6'b000001, 4'd2, 1'b1, 1);
        force_low = MAX_WAIT + 1;
        run_instr(2'b01, 6'b000000, 4'd3, 1'b1, 99);
`endif

        for (int n = 0; n < 300; n++) begin
            logic [1:0] ro;
            logic [5:0] rf;
            logic [3:0] rr;
            logic       rc;
            ro = 2'($urandom_range(0, 3));
            rf = 6'($urandom);
            rr = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            rc = ($urandom_range(0, 3) != 0);
            run_instr(ro, rf, rr, rc, 99);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
